dmux8way_arbiter: RTL and testbench
===================================

# dmux8way_arbiter

Round-robin arbiter that shares one 8-way demultiplexed write path among eight requesters. The block registers a one-hot grant and its 3-bit index `sel`. It routes the owning requester's write strobe through an internal `dmux8way_gate` to the matching `load_out` bit. It sits in front of RAM8-style register banks so that several producers can take turns driving the bank's load lines.

## Interface
- `MAX_HOLD`, 4: maximum consecutive grant cycles for one owner while others wait. Used only when `ARB_HOLD_LIMIT_EN` is defined. Legal range 1–255.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 8: request vector. Bit i means requester i wants the path.
- `load_in` input 1: write strobe from the current owner.
- `gnt` output 8: registered one-hot grant, or all zeros when idle.
- `sel` output 3: registered index of the owner. It drives the select input of the internal dmux.
- `busy` output 1: registered. It is 1 whenever `gnt` is nonzero.
- `load_out` output 8: combinational. `load_in` is routed to bit `sel` through `dmux8way_gate` only when `busy`=1. Otherwise all zeros.
- `preempt` output 1: registered one-cycle pulse marking a forced release. It is tied to 0 when `ARB_HOLD_LIMIT_EN` is undefined.

## Operation
- The FSM has two states, IDLE and GRANT.
- Reset value of every output: `gnt`=0, `sel`=0, `busy`=0, `preempt`=0, `load_out`=0. The internal round-robin pointer `last` resets to 7, so requester 0 has top priority after reset.
- Arbitration picks the first set `req` bit scanning (last+1) mod 8, (last+2) mod 8, … up to `last`. The scan wraps from 7 to 0.
- IDLE:
  - If `req` is nonzero, arbitrate and go to GRANT.
  - On that edge, load `gnt`/`sel` with the winner and set `last` to the winner.
  - Otherwise stay in IDLE.
- GRANT, owner still requesting (`req[sel]`=1): hold `gnt`, `sel` and `last` unchanged.
- GRANT, owner drops `req[sel]`: re-arbitrate on the same edge among the remaining bits.
  - If there is a winner, grant it, with no idle cycle in between.
  - If there is none, go to IDLE and clear `gnt`/`busy`.
- Simultaneous requests: round-robin order decides. No requester can be granted twice while another waits, provided each owner eventually releases (or is preempted).
- `req` bits other than the owner's never affect the current grant, except through the preemption rule.
- `load_out` is gated by `busy`, so a `load_in` pulse while IDLE produces no write.
- Asynchronous `reset` mid-grant immediately clears all outputs and restores `last`=7. This holds even when `load_in` is high.

## Timing
- Request-to-grant latency is 1 cycle: a `req` sampled at edge N gives `gnt` valid after edge N.
- Release-to-handover is 1 edge: the owner deasserts `req` in cycle N, and the next owner's `gnt` appears after edge N.
- `load_out` has zero latency from `load_in`.
- `gnt`, `sel` and `busy` change only on rising `clk` or on assertion of `reset`.

## Configuration
- Macro `ARB_HOLD_LIMIT_EN`.
- Defined: a hold counter is added. Its width is the ceiling of log2(MAX_HOLD+1).
  - The counter clears on each new grant and increments on each GRANT-state cycle.
  - When the count equals `MAX_HOLD` and any other `req` bit is set, the block re-arbitrates excluding the owner, and pulses `preempt` for 1 cycle.
  - If no other requester is waiting, the counter saturates and the grant is kept.
- Undefined: there is no counter. Ownership lasts until the owner drops `req`, and `preempt` is constant 0.

## Test plan
- Reset check: assert `reset` with `req`=8'hFF → `gnt`=0, `busy`=0, `load_out`=0. Deassert `reset` → after 1 edge, `gnt`=8'h01 and `sel`=0.
- Rotation: hold `req`=8'hFF and drop each owner's bit for 1 cycle after each grant → grants arrive in order 0,1,2,…,7,0 with no idle cycles.
- Wrap priority: owner 6 releases while `req`=8'h41 → next grant is `gnt`=8'h01 (bit 0 beats bit 6 after the wrap from 7 to 0).
- Load routing: grant index 5, then pulse `load_in` → `load_out`=8'h20 for exactly that cycle. `load_in` pulsed while idle → `load_out`=0.
- Mid-grant reset: owner 3 active with `load_in`=1, assert `reset` asynchronously → `gnt`=0 and `load_out`=0 before the next edge. After release of `reset`, `req`=8'h08 is granted as index 3.
- With `ARB_HOLD_LIMIT_EN` and `MAX_HOLD`=4, `req`=8'h03 held constant → owner 0 holds for 4 cycles, then `preempt`=1 for 1 cycle and `gnt`=8'h02. With `req`=8'h01 only → the grant is held indefinitely and `preempt` stays 0.

Source files
------------

// File: rtl/dmux8way_arbiter_if.sv
// Purpose : bundle of the arbiter's request, write-strobe and grant signals.
// Latency : none; wires only.
// Backpressure: none; a requester holds its req bit until it is granted.
// Ports   : req[7:0], load_in (requester side); gnt[7:0], sel[2:0], busy,
//           load_out[7:0], preempt (arbiter side).
interface dmux8way_arbiter_if;
  logic [7:0] req;
  logic       load_in;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] load_out;
  logic       preempt;

  // Requester / bank side.
  modport master (
    output req, load_in,
    input  gnt, sel, busy, load_out, preempt
  );

  // Arbiter side.
  modport slave (
    input  req, load_in,
    output gnt, sel, busy, load_out, preempt
  );
endinterface

// File: rtl/dmux8way_arbiter.sv
// Purpose : round-robin arbiter over eight requesters steering one write strobe
//           through an 8-way demux onto the owner's load line.
// Latency : 1 cycle req->gnt and release->handover; load_in->load_out is 0 cycles.
// Backpressure: a requester waits with req held until granted; the owner keeps
//           the path until it drops req (or is preempted when the hold limit is on).
// Ports   : clk, reset (async, active high); bus (dmux8way_arbiter_if.slave).
// Option  : define ARB_HOLD_LIMIT_EN to cap ownership at MAX_HOLD cycles while
//           others wait; otherwise preempt is constant 0.

// Purpose : 1-to-8 demux of a single strobe onto the line selected by sel.
// Latency : combinational.
// Backpressure: none.
module dmux8way_gate (
  input  logic       in,
  input  logic [2:0] sel,
  output logic [7:0] out
);
  always_comb begin
    out      = 8'h00;
    out[sel] = in;
  end
endmodule

module dmux8way_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dmux8way_arbiter_if.slave    bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("dmux8way_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [7:0] gnt, gnt_n;
  logic [2:0] sel, sel_n;
  logic [2:0] last, last_n;
  logic       busy, busy_n;

  // Returns {found, index}: first set bit scanning last+1, last+2, ... last.
  // Iterating from the far end lets the nearest candidate overwrite the rest.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] l);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'h0;
    for (int k = 8; k >= 1; k--) begin
      idx = l + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [3:0] pick_any;
  logic [3:0] pick_oth;
  logic       take;
  logic [2:0] win;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold_cnt, hold_cnt_n;
  logic          preempt_q, preempt_n;
`endif

  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    sel_n    = sel;
    last_n   = last;
    busy_n   = busy;
    take     = 1'b0;
    win      = 3'd0;
`ifdef ARB_HOLD_LIMIT_EN
    preempt_n  = 1'b0;
    hold_cnt_n = hold_cnt;
`endif
    pick_any = rr_pick(bus.req, last);
    // Everyone except the current owner; used on release and on preemption.
    pick_oth = rr_pick(bus.req & ~gnt, last);

    case (state)
      IDLE: begin
        if (pick_any[3]) begin
          take = 1'b1;
          win  = pick_any[2:0];
        end
      end
      GRANT: begin
        if (bus.req[sel]) begin
`ifdef ARB_HOLD_LIMIT_EN
          // hold_cnt counts completed cycles, so the current cycle is number
          // hold_cnt+1; at MAX_HOLD the owner yields to any waiting requester.
          if (hold_cnt >= CW'(MAX_HOLD - 1) && pick_oth[3]) begin
            take      = 1'b1;
            win       = pick_oth[2:0];
            preempt_n = 1'b1;
          end else if (hold_cnt != CW'(MAX_HOLD)) begin
            hold_cnt_n = hold_cnt + CW'(1);
          end
`endif
        end else if (pick_oth[3]) begin
          take = 1'b1;
          win  = pick_oth[2:0];
        end else begin
          state_n = IDLE;
          gnt_n   = 8'h00;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      state_n = GRANT;
      gnt_n   = 8'd1 << win;
      sel_n   = win;
      last_n  = win;
      busy_n  = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_n = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 8'h00;
      sel   <= 3'd0;
      last  <= 3'd7;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      last  <= last_n;
      busy  <= busy_n;
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_cnt  <= hold_cnt_n;
      preempt_q <= preempt_n;
    end
  end
  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = 1'b0;
`endif

  assign bus.gnt  = gnt;
  assign bus.sel  = sel;
  assign bus.busy = busy;

  // Strobe reaches the bank only while someone owns the path.
  dmux8way_gate u_gate (
    .in  (bus.load_in & busy),
    .sel (sel),
    .out (bus.load_out)
  );

endmodule

// File: tb/tb_dmux8way_arbiter.sv
// Purpose : directed, table-driven bench for dmux8way_arbiter.
// Latency : inputs change #1 after a rising edge; outputs sampled #1 after the next.
// Backpressure: n/a.
module tb_dmux8way_arbiter;

  logic clk;
  logic reset;

  dmux8way_arbiter_if bus_if ();

  dmux8way_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic       load_in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] load_out;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic b, input logic [7:0] lo, input logic p);
    check({tag, ".gnt"},      32'(bus_if.gnt),      32'(g));
    check({tag, ".sel"},      32'(bus_if.sel),      32'(s));
    check({tag, ".busy"},     32'(bus_if.busy),     32'(b));
    check({tag, ".load_out"}, 32'(bus_if.load_out), 32'(lo));
    check({tag, ".preempt"},  32'(bus_if.preempt),  32'(p));
  endtask

  // Drive inputs away from the edge, take one edge, sample just after it.
  task automatic step(input logic [7:0] r, input logic li);
    bus_if.req     = r;
    bus_if.load_in = li;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] r, input logic li, input logic [7:0] g,
                              input logic [2:0] s, input logic b, input logic [7:0] lo);
    vec_t v;
    v.req = r; v.load_in = li; v.gnt = g; v.sel = s; v.busy = b; v.load_out = lo;
    return v;
  endfunction

  initial begin
    // Rotation 0..7..0 with one-cycle drops, load routing on owner 5.
    vecs.push_back(mk(8'hFE, 1'b0, 8'h02, 3'd1, 1'b1, 8'h00));
    vecs.push_back(mk(8'hFD, 1'b0, 8'h04, 3'd2, 1'b1, 8'h00));
    vecs.push_back(mk(8'hFB, 1'b0, 8'h08, 3'd3, 1'b1, 8'h00));
    vecs.push_back(mk(8'hF7, 1'b0, 8'h10, 3'd4, 1'b1, 8'h00));
    vecs.push_back(mk(8'hEF, 1'b0, 8'h20, 3'd5, 1'b1, 8'h00));
    vecs.push_back(mk(8'hFF, 1'b1, 8'h20, 3'd5, 1'b1, 8'h20));
    vecs.push_back(mk(8'hFF, 1'b0, 8'h20, 3'd5, 1'b1, 8'h00));
    vecs.push_back(mk(8'hDF, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00));
    vecs.push_back(mk(8'hBF, 1'b0, 8'h80, 3'd7, 1'b1, 8'h00));
    vecs.push_back(mk(8'h7F, 1'b0, 8'h01, 3'd0, 1'b1, 8'h00));
    // Wrap priority: get owner 6, then it releases with bit 0 waiting.
    vecs.push_back(mk(8'h40, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00));
    vecs.push_back(mk(8'h41, 1'b0, 8'h40, 3'd6, 1'b1, 8'h00));
    vecs.push_back(mk(8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 8'h00));
    // Idle, strobe while idle, then a fresh single request.
    vecs.push_back(mk(8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00));
    vecs.push_back(mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00));
    vecs.push_back(mk(8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 8'h00));
    vecs.push_back(mk(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 8'h08));

    // Reset with everyone requesting.
    reset          = 1'b1;
    bus_if.req     = 8'hFF;
    bus_if.load_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    reset          = 1'b0;
    bus_if.load_in = 1'b0;
    step(8'hFF, 1'b0);
    check_all("first_grant", 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].load_in);
      check_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy,
                vecs[i].load_out, 1'b0);
    end

    // Mid-grant asynchronous reset: owner 3 with load_in high.
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_all("async_reset", 8'h00, 3'd0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(8'h08, 1'b0);
    check_all("post_reset_grant", 8'h08, 3'd3, 1'b1, 8'h00, 1'b0);

    // Pointer restored to 7: with last stale at 3, 8'h82 would go to 7.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step(8'h82, 1'b0);
    check_all("ptr_restored", 8'h02, 3'd1, 1'b1, 8'h00, 1'b0);

    // Hold behaviour with a second requester waiting.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    step(8'h03, 1'b0);
    check_all("hold_c1", 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);
    for (int c = 2; c <= 4; c++) begin
      step(8'h03, 1'b0);
      check_all($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);
    end
`ifdef ARB_HOLD_LIMIT_EN
    step(8'h03, 1'b0);
    check_all("preempt", 8'h02, 3'd1, 1'b1, 8'h00, 1'b1);
    step(8'h03, 1'b0);
    check_all("preempt_pulse_end", 8'h02, 3'd1, 1'b1, 8'h00, 1'b0);
    step(8'h01, 1'b0);
    check_all("alone_grant", 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(8'h01, 1'b0);
      check_all($sformatf("alone_hold%0d", c), 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);
    end
`else
    for (int c = 5; c < 15; c++) begin
      step(8'h03, 1'b0);
      check_all($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1, 8'h00, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
